// File: rtl/mpe_operand_streamer_if.sv
// Operand streamer bundle: command, SRAM read port and PE-facing stream.
// cmd_stride exists only when MPE_STREAM_STRIDE_EN is defined.
interface mpe_operand_streamer_if #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;
`ifdef MPE_STREAM_STRIDE_EN
  logic [ADDR_W-1:0] cmd_stride;
`endif
  logic              sram_rd_en;
  logic [ADDR_W-1:0] sram_rd_addr;
  logic [DATA_W-1:0] sram_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  modport master (
`ifdef MPE_STREAM_STRIDE_EN
    input  cmd_stride,
`endif
    input  cmd_valid, cmd_addr, cmd_len, sram_rd_data, out_ready,
    output cmd_ready, sram_rd_en, sram_rd_addr, out_data, out_valid, busy, done
  );

  modport slave (
`ifdef MPE_STREAM_STRIDE_EN
    output cmd_stride,
`endif
    output cmd_valid, cmd_addr, cmd_len, sram_rd_data, out_ready,
    input  cmd_ready, sram_rd_en, sram_rd_addr, out_data, out_valid, busy, done
  );
endinterface

// File: rtl/mpe_operand_streamer.sv
// Streams a contiguous run of operand SRAM words to the matrix PE through a 2-entry buffer.
// Optional MPE_STREAM_STRIDE_EN adds a per-command address stride (default stride is 1).
module mpe_operand_streamer #(
  parameter int unsigned DATA_W = 512,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mpe_operand_streamer_if.master io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] step;
  logic [LEN_W-1:0]  rem_q;
  logic              rd_pend_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        count_q;
  logic [DATA_W-1:0] head_q;
  logic [DATA_W-1:0] tail_q;

  logic              accept_c;
  logic              pop_c;
  logic              rd_en_c;
  logic              last_beat_c;
  logic [2:0]        occ_c;

  // A read may issue when the buffer can still absorb it; a pop this cycle frees a slot.
  assign accept_c    = (state_q == IDLE) && io.cmd_valid;
  assign pop_c       = (count_q != 2'd0) && io.out_ready;
  assign occ_c       = 3'(count_q) + 3'(rd_pend_q) - 3'(pop_c);
  assign rd_en_c     = (state_q == RUN) && (occ_c < 3'd2);
  assign last_beat_c = pop_c && (count_q == 2'd1) && !rd_pend_q;

  assign io.cmd_ready    = (state_q == IDLE);
  assign io.sram_rd_en   = rd_en_c;
  assign io.sram_rd_addr = addr_q;
  assign io.out_data     = head_q;
  assign io.out_valid    = (count_q != 2'd0);
  assign io.busy         = busy_q;
  assign io.done         = done_q;

`ifdef MPE_STREAM_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stride_q <= '0;
    end else if (accept_c) begin
      stride_q <= io.cmd_stride;
    end
  end

  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // Command FSM, read address/count and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rem_q     <= '0;
      rd_pend_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      rd_pend_q <= rd_en_c;
      if (rd_en_c) begin
        addr_q <= addr_q + step;
        rem_q  <= rem_q - LEN_W'(1);
      end
      case (state_q)
        IDLE: begin
          busy_q <= 1'b0;
          if (accept_c) begin
            addr_q <= io.cmd_addr;
            rem_q  <= io.cmd_len;
            busy_q <= 1'b1;
            if (io.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (rd_en_c && (rem_q == LEN_W'(1))) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (last_beat_c) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry output buffer; read data lands the cycle after the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 2'd0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case ({rd_pend_q, pop_c})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_q <= io.sram_rd_data;
          end else begin
            tail_q <= io.sram_rd_data;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_q  <= tail_q;
          count_q <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd2) begin
            head_q <= tail_q;
            tail_q <= io.sram_rd_data;
          end else begin
            head_q <= io.sram_rd_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpe_operand_streamer.sv
// Scoreboard bench for mpe_operand_streamer: stimulus queues expected words/addresses/done times,
// a negedge monitor compares them against the stream and the SRAM read port.
module tb_mpe_operand_streamer;
  localparam int unsigned DATA_W = 512;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LEN_W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mpe_operand_streamer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) io ();

  mpe_operand_streamer #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int beats = 0;
  int last_beat_cyc = -10;
  int exp_first = -1;
  int rdy_mode = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0] exp_addr_q[$];
  int                exp_done_q[$];

  // Monitor-private state
  int                landed = 0;
  int                popped = 0;
  int                buffered = 0;
  bit                pend = 1'b0;
  bit                prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_data;
  int                d;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    logic [15:0] x;
    x = a ^ 16'h3c5a;
    return {16{~a, x}};
  endfunction

  task automatic chk_w(input string name, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", name, got, exp);
    end
  endtask

  task automatic chk_i(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  // Synchronous-read SRAM model with address-derived contents
  always @(posedge clk) if (io.sram_rd_en) io.sram_rd_data <= mem_word(io.sram_rd_addr);

  always @(posedge clk) cyc <= cyc + 1;

  // Sink ready: constant or random per cycle
  initial begin
    io.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      io.out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        landed = 0; popped = 0; pend = 1'b0; prev_stall = 1'b0;
        continue;
      end
      buffered = landed - popped;
      checks++;
      if (buffered > 2) begin
        errors++;
        $display("FAIL occupancy got %0d exp <=2 (cycle %0d)", buffered, cyc);
      end
      chk_i("out_valid_vs_occupancy", int'(io.out_valid), (buffered != 0) ? 1 : 0);
      if (prev_stall) begin
        chk_i("stall_valid_held", int'(io.out_valid), 1);
        chk_w("stall_data_held", io.out_data, prev_data);
      end
      if (io.sram_rd_en) begin
        if (exp_addr_q.size() == 0) flag("unexpected_sram_read");
        else chk_i("rd_addr", int'(io.sram_rd_addr), int'(exp_addr_q.pop_front()));
      end
      if (io.out_valid && io.out_ready) begin
        beats++;
        if (exp_q.size() == 0) flag("unexpected_beat");
        else chk_w("beat_data", io.out_data, exp_q.pop_front());
        if (exp_first >= 0) begin
          chk_i("first_beat_cycle", cyc, exp_first);
          exp_first = -1;
        end
        last_beat_cyc = cyc;
        popped++;
      end
      if (io.done) begin
        chk_i("beats_left_at_done", exp_q.size(), 0);
        if (exp_done_q.size() == 0) flag("unexpected_done");
        else begin
          d = exp_done_q.pop_front();
          chk_i("done_cycle", cyc, (d >= 0) ? d : last_beat_cyc + 1);
        end
      end
      if (pend) landed++;
      pend = io.sram_rd_en;
      prev_stall = io.out_valid && !io.out_ready;
      prev_data = io.out_data;
    end
  end

  task automatic check_reset_values();
    chk_i("rst_cmd_ready", int'(io.cmd_ready), 1);
    chk_i("rst_sram_rd_en", int'(io.sram_rd_en), 0);
    chk_i("rst_sram_rd_addr", int'(io.sram_rd_addr), 0);
    chk_i("rst_out_valid", int'(io.out_valid), 0);
    chk_w("rst_out_data", io.out_data, '0);
    chk_i("rst_busy", int'(io.busy), 0);
    chk_i("rst_done", int'(io.done), 0);
  endtask

  task automatic clear_expect();
    exp_q.delete();
    exp_addr_q.delete();
    exp_done_q.delete();
    exp_first = -1;
  endtask

  // Queue expectations, then present the command for one accept cycle T
  task automatic send_cmd(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] len,
                          input logic [ADDR_W-1:0] stride, input bit timed);
    int t;
    logic [ADDR_W-1:0] a;
    for (int i = 0; i < int'(len); i++) begin
      a = ADDR_W'(addr + ADDR_W'(i) * stride);
      exp_addr_q.push_back(a);
      exp_q.push_back(mem_word(a));
    end
    @(negedge clk);
    t = cyc;
    io.cmd_addr = addr;
    io.cmd_len = len;
`ifdef MPE_STREAM_STRIDE_EN
    io.cmd_stride = stride;
`endif
    io.cmd_valid = 1'b1;
    chk_i("cmd_ready_idle", int'(io.cmd_ready), 1);
    if (len == '0) exp_done_q.push_back(t + 1);
    else if (timed) begin
      exp_first = t + 3;
      exp_done_q.push_back(t + 3 + int'(len));
    end else exp_done_q.push_back(-1);
    @(posedge clk);
    #1;
    io.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && exp_addr_q.size() == 0 && exp_done_q.size() == 0 && !io.busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      flag("wait_idle_timeout");
      clear_expect();
    end
  endtask

  initial begin
    int b0;
    bit reached;
    io.cmd_valid = 1'b0;
    io.cmd_addr = '0;
    io.cmd_len = '0;
`ifdef MPE_STREAM_STRIDE_EN
    io.cmd_stride = ADDR_W'(1);
`endif
    repeat (3) @(negedge clk);
    check_reset_values();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full-rate stream with exact latency and done timing
    rdy_mode = 0;
    send_cmd(16'd0, 16'd140, 16'd1, 1'b1);
    wait_idle(400);

    // Same stream under random backpressure
    rdy_mode = 1;
    send_cmd(16'd0, 16'd140, 16'd1, 1'b0);
    wait_idle(3000);
    rdy_mode = 0;

    // Zero-length command: done next cycle, busy for one cycle, no reads
    send_cmd(16'd100, 16'd0, 16'd1, 1'b1);
    @(negedge clk);
    chk_i("len0_busy_t1", int'(io.busy), 1);
    @(negedge clk);
    chk_i("len0_busy_t2", int'(io.busy), 0);
    wait_idle(20);

    // Address wrap at the top of the SRAM
    send_cmd(16'hFFFE, 16'd4, 16'd1, 1'b1);
    wait_idle(40);

    // Reset mid-stream after 50 beats, then a fresh command
    b0 = beats;
    send_cmd(16'd0, 16'd140, 16'd1, 1'b0);
    reached = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (beats >= b0 + 50) begin
        reached = 1'b1;
        break;
      end
    end
    if (!reached) flag("mid_stream_50_beats_timeout");
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    clear_expect();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    send_cmd(16'd10, 16'd3, 16'd1, 1'b1);
    wait_idle(40);

`ifdef MPE_STREAM_STRIDE_EN
    send_cmd(16'd4, 16'd4, 16'd3, 1'b1);
    wait_idle(40);
    send_cmd(16'd4, 16'd3, 16'd0, 1'b1);
    wait_idle(40);
`endif

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
